// File: rtl/core_bus_pkg.sv
// Shared types for the core bus arbiter: FSM states, default-width request
// slot record and small sizing helpers.
package core_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = DEF_DATA_W / 8;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  write;
    logic [DEF_DATA_W-1:0] data;
    logic [BE_W-1:0]       be;
  } slot_t;

  // Counter width able to hold 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/core_bus_arb_pick.sv
// Combinational requester picker: rotating priority starting after last_grant,
// or plain lowest-index priority when fixed_prio is set.
module core_bus_arb_pick
  import core_bus_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             fixed_prio,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  int idx;

  // Loops run from the far end so the highest-priority hit is the last write.
  always_comb begin
    idx   = 0;
    grant = '0;
    valid = |pending;
    if (fixed_prio) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pending[i]) grant = IDX_W'(i);
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        idx = (int'(last_grant) + k) % N;
        if (pending[idx[IDX_W-1:0]]) grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// N-channel request arbiter onto one shared start/ready bus, with per-channel
// request slots, round-robin or fixed priority, and an optional watchdog.
//
// state | meaning
// IDLE  | no transfer on the bus; pick a pending channel and load bus fields
// ISSUE | bus_start high for this single cycle
// WAIT  | waiting for bus_ready (or watchdog expiry) for the granted channel
module core_bus_arbiter #(
  parameter int N          = 2,
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            ch_start,
  input  logic [N-1:0]            ch_write,
  input  logic [N*ADDR_W-1:0]     ch_addr,
  input  logic [N*DATA_W-1:0]     ch_data_wr,
  input  logic [N*DATA_W/8-1:0]   ch_data_be,
  output logic [N-1:0]            ch_ready,
  output logic [N-1:0]            ch_fault,
  output logic [DATA_W-1:0]       ch_data_rd,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic                    bus_start,
  output logic                    bus_write,
  output logic [DATA_W-1:0]       bus_data_wr,
  output logic [DATA_W/8-1:0]     bus_data_be,
  input  logic                    bus_ready,
  input  logic [DATA_W-1:0]       bus_data_rd
);
  import core_bus_pkg::*;

  localparam int SLOT_BE_W = DATA_W / 8;
  localparam int IDX_W     = $clog2(N);
  localparam int TMO_W     = cnt_w(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic                 write;
    logic [DATA_W-1:0]    data;
    logic [SLOT_BE_W-1:0] be;
  } ch_slot_t;

  ch_slot_t         slot [N];
  logic [N-1:0]     pending;
  arb_state_t       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] pick_grant;
  logic             pick_valid;
  logic [TMO_W-1:0] tmo_cnt;
  logic             done_ok;
  logic             done_tmo;
  logic [N-1:0]     grant_oh;
  logic [N-1:0]     clr_mask;
  logic [N-1:0]     set_mask;

  core_bus_arb_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // A new start on a channel completing this cycle is accepted; otherwise a
  // start on an already pending channel is dropped.
  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
    done_ok  = !rst && (state == WAIT) && bus_ready;
    done_tmo = !rst && (state == WAIT) && !bus_ready && (TIMEOUT > 0) &&
               (tmo_cnt == TMO_LAST);
    ch_ready = done_ok  ? grant_oh : '0;
    ch_fault = done_tmo ? grant_oh : '0;
    clr_mask = ch_ready | ch_fault;
    set_mask = ch_start & (~pending | clr_mask);
  end

  assign ch_data_rd = bus_data_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      last_grant  <= IDX_W'(N - 1);
      grant       <= '0;
      tmo_cnt     <= '0;
      bus_start   <= 1'b0;
      bus_addr    <= '0;
      bus_write   <= 1'b0;
      bus_data_wr <= '0;
      bus_data_be <= '0;
    end else begin
      pending   <= (pending & ~clr_mask) | set_mask;
      bus_start <= 1'b0;
      for (int i = 0; i < N; i++) begin
        if (set_mask[i]) begin
          slot[i] <= '{addr:  ch_addr[i*ADDR_W +: ADDR_W],
                       write: ch_write[i],
                       data:  ch_data_wr[i*DATA_W +: DATA_W],
                       be:    ch_data_be[i*SLOT_BE_W +: SLOT_BE_W]};
        end
      end
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant       <= pick_grant;
            bus_addr    <= slot[pick_grant].addr;
            bus_write   <= slot[pick_grant].write;
            bus_data_wr <= slot[pick_grant].data;
            bus_data_be <= slot[pick_grant].be;
            bus_start   <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (done_ok) begin
            last_grant <= grant;
            state      <= IDLE;
          end else if (done_tmo) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: a round-robin instance with an
// 8-cycle watchdog and a fixed-priority instance, checked against rule models.
module tb_core_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_rr, rst_fp, sel_fp;
  logic [N-1:0]    ch_start, ch_write;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_data_wr;
  logic [N*BW-1:0] ch_data_be;
  logic            bus_ready;
  logic [DW-1:0]   bus_data_rd;

  logic [N-1:0]  rr_ch_ready, rr_ch_fault, fp_ch_ready, fp_ch_fault;
  logic [DW-1:0] rr_ch_data_rd, fp_ch_data_rd, rr_bus_data_wr, fp_bus_data_wr;
  logic [AW-1:0] rr_bus_addr, fp_bus_addr;
  logic          rr_bus_start, fp_bus_start, rr_bus_write, fp_bus_write;
  logic [BW-1:0] rr_bus_data_be, fp_bus_data_be;

  logic [N-1:0]  obs_ch_ready, obs_ch_fault;
  logic [DW-1:0] obs_ch_data_rd, obs_bus_data_wr;
  logic [AW-1:0] obs_bus_addr;
  logic          obs_bus_start, obs_bus_write;
  logic [BW-1:0] obs_bus_data_be;

  int n_checks = 0;
  int n_fail   = 0;

  core_bus_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst_rr), .ch_start(ch_start), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_data_wr(ch_data_wr), .ch_data_be(ch_data_be), .ch_ready(rr_ch_ready),
    .ch_fault(rr_ch_fault), .ch_data_rd(rr_ch_data_rd), .bus_addr(rr_bus_addr),
    .bus_start(rr_bus_start), .bus_write(rr_bus_write), .bus_data_wr(rr_bus_data_wr),
    .bus_data_be(rr_bus_data_be), .bus_ready(bus_ready), .bus_data_rd(bus_data_rd));

  core_bus_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst_fp), .ch_start(ch_start), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_data_wr(ch_data_wr), .ch_data_be(ch_data_be), .ch_ready(fp_ch_ready),
    .ch_fault(fp_ch_fault), .ch_data_rd(fp_ch_data_rd), .bus_addr(fp_bus_addr),
    .bus_start(fp_bus_start), .bus_write(fp_bus_write), .bus_data_wr(fp_bus_data_wr),
    .bus_data_be(fp_bus_data_be), .bus_ready(bus_ready), .bus_data_rd(bus_data_rd));

  assign obs_ch_ready    = sel_fp ? fp_ch_ready    : rr_ch_ready;
  assign obs_ch_fault    = sel_fp ? fp_ch_fault    : rr_ch_fault;
  assign obs_ch_data_rd  = sel_fp ? fp_ch_data_rd  : rr_ch_data_rd;
  assign obs_bus_addr    = sel_fp ? fp_bus_addr    : rr_bus_addr;
  assign obs_bus_start   = sel_fp ? fp_bus_start   : rr_bus_start;
  assign obs_bus_write   = sel_fp ? fp_bus_write   : rr_bus_write;
  assign obs_bus_data_wr = sel_fp ? fp_bus_data_wr : rr_bus_data_wr;
  assign obs_bus_data_be = sel_fp ? fp_bus_data_be : rr_bus_data_be;

  always #5 clk = ~clk;

  // Requesters must not restart a channel that is still outstanding.
  logic [N-1:0] tb_out;
  always @(posedge clk) begin
    if (rst_rr) begin
      tb_out <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        assert (!(ch_start[i] && tb_out[i] && !(rr_ch_ready[i] || rr_ch_fault[i])))
          else $error("protocol violation: restart of outstanding channel %0d", i);
      tb_out <= (tb_out & ~(rr_ch_ready | rr_ch_fault)) | ch_start;
    end
  end

  // Arbitration rule: lowest pending index, or first pending after 'last'.
  function automatic int rule_pick(input logic [N-1:0] pend, input int last, input bit fp);
    if (fp) begin
      for (int i = 0; i < N; i++) if (pend[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    ch_start  = '0;
    bus_ready = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    ch_start[i]              = 1'b1;
    ch_write[i]              = wr;
    ch_addr[i*AW +: AW]      = a;
    ch_data_wr[i*DW +: DW]   = d;
    ch_data_be[i*BW +: BW]   = be;
  endtask

  task automatic do_reset(input bit fp);
    sel_fp = fp;
    next_cycle();
    rst_rr = 1'b1;
    rst_fp = 1'b1;
    next_cycle();
    next_cycle();
    if (fp) rst_fp = 1'b0;
    else    rst_rr = 1'b0;
  endtask

  task automatic test_reset();
    sel_fp = 1'b0;
    rst_rr = 1'b1;
    rst_fp = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    n_checks++; if (obs_bus_start !== 1'b0) begin n_fail++; $display("FAIL reset_bus_start got %b want 0", obs_bus_start); end
    n_checks++; if (obs_bus_addr !== '0) begin n_fail++; $display("FAIL reset_bus_addr got %h want 0", obs_bus_addr); end
    n_checks++; if (obs_bus_write !== 1'b0) begin n_fail++; $display("FAIL reset_bus_write got %b want 0", obs_bus_write); end
    n_checks++; if (obs_bus_data_wr !== '0) begin n_fail++; $display("FAIL reset_bus_data_wr got %h want 0", obs_bus_data_wr); end
    n_checks++; if (obs_bus_data_be !== '0) begin n_fail++; $display("FAIL reset_bus_data_be got %h want 0", obs_bus_data_be); end
    n_checks++; if (obs_ch_ready !== '0) begin n_fail++; $display("FAIL reset_ch_ready got %b want 0", obs_ch_ready); end
    n_checks++; if (obs_ch_fault !== '0) begin n_fail++; $display("FAIL reset_ch_fault got %b want 0", obs_ch_fault); end
  endtask

  task automatic test_single_read();
    do_reset(1'b0);
    for (int t = 0; t < 6; t++) begin
      next_cycle();
      if (t == 0) set_req(0, 1'b0, 30'h100, 32'h0, 4'hF);
      if (t == 4) begin bus_ready = 1'b1; bus_data_rd = 32'hDEADBEEF; end
      #1;
      n_checks++; if (obs_bus_start !== (t == 2)) begin n_fail++; $display("FAIL single_bus_start t=%0d got %b want %b", t, obs_bus_start, (t == 2)); end
      if (t == 2) begin
        n_checks++; if (obs_bus_addr !== 30'h100) begin n_fail++; $display("FAIL single_bus_addr got %h want 100", obs_bus_addr); end
        n_checks++; if (obs_bus_write !== 1'b0) begin n_fail++; $display("FAIL single_bus_write got %b want 0", obs_bus_write); end
      end
      n_checks++; if (obs_ch_ready !== ((t == 4) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_ch_ready t=%0d got %b", t, obs_ch_ready); end
      if (t == 4) begin
        n_checks++; if (obs_ch_data_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data_rd got %h want deadbeef", obs_ch_data_rd); end
      end
    end
  endtask

  task automatic test_rr_order();
    int exp_q[$];
    logic [N-1:0] pend, mask;
    int m_last, cnt, k_iss, k_done, rdy_at, last_st, t, g;
    do_reset(1'b0);
    m_last = N - 1;
    for (int ph = 0; ph < 2; ph++) begin
      mask = (ph == 0) ? 4'b1111 : 4'b1010;
      next_cycle();
      for (int i = 0; i < N; i++)
        if (mask[i]) set_req(i, 1'(i), AW'(32'h200 + i), 32'h1000 + i, 4'hF);
      exp_q.delete();
      pend = mask;
      while (pend != 0) begin
        g = rule_pick(pend, m_last, 1'b0);
        exp_q.push_back(g);
        pend[g] = 1'b0;
        m_last = g;
      end
      cnt = exp_q.size();
      k_iss = 0; k_done = 0; rdy_at = -1; last_st = 0; t = 0;
      while (k_done < cnt && t < 40) begin
        next_cycle();
        t++;
        if (t == rdy_at) begin bus_ready = 1'b1; bus_data_rd = $urandom; end
        #1;
        if (obs_bus_start === 1'b1) begin
          n_checks++; if (k_iss >= cnt || obs_bus_addr !== AW'(32'h200 + exp_q[k_iss % cnt])) begin n_fail++; $display("FAIL rr_issue ph=%0d k=%0d got addr %h want ch %0d", ph, k_iss, obs_bus_addr, exp_q[k_iss % cnt]); end
          if (k_iss > 0) begin
            n_checks++; if (t - last_st != 3) begin n_fail++; $display("FAIL rr_spacing got %0d want 3", t - last_st); end
          end
          last_st = t; rdy_at = t + 1; k_iss++;
        end
        if (obs_ch_ready !== '0) begin
          n_checks++; if (obs_ch_ready !== (4'b0001 << exp_q[k_done % cnt])) begin n_fail++; $display("FAIL rr_ready k=%0d got %b want ch %0d", k_done, obs_ch_ready, exp_q[k_done % cnt]); end
          n_checks++; if (obs_ch_data_rd !== bus_data_rd) begin n_fail++; $display("FAIL rr_data_rd got %h want %h", obs_ch_data_rd, bus_data_rd); end
          k_done++;
        end
      end
      n_checks++; if (k_done != cnt) begin n_fail++; $display("FAIL rr_budget ph=%0d got %0d done want %0d", ph, k_done, cnt); end
    end
  endtask

  task automatic test_starve(input bit fp);
    logic [N-1:0] pend;
    int m_last, served3, k, t, rdy_at, cur_g;
    do_reset(fp);
    next_cycle();
    set_req(0, 1'b0, 30'h300, 32'h0, 4'hF);
    set_req(3, 1'b0, 30'h303, 32'h0, 4'hF);
    pend = 4'b1001; m_last = N - 1; served3 = -1; k = 0; t = 0; rdy_at = -1; cur_g = 0;
    while (k < 5 && t < 60) begin
      next_cycle();
      t++;
      if (t == rdy_at) bus_ready = 1'b1;
      #1;
      if (obs_bus_start === 1'b1) begin
        cur_g = rule_pick(pend, m_last, fp);
        n_checks++; if (obs_bus_addr !== AW'(32'h300 + cur_g)) begin n_fail++; $display("FAIL starve_issue fp=%0d k=%0d got addr %h want ch %0d", fp, k, obs_bus_addr, cur_g); end
        rdy_at = t + 1;
      end
      if (obs_ch_ready !== '0) begin
        n_checks++; if (obs_ch_ready !== (4'b0001 << cur_g)) begin n_fail++; $display("FAIL starve_ready fp=%0d got %b want ch %0d", fp, obs_ch_ready, cur_g); end
        if (cur_g == 3) begin served3 = k; pend[3] = 1'b0; end
        else set_req(0, 1'b0, 30'h300, 32'h0, 4'hF);
        m_last = cur_g;
        k++;
      end
    end
    n_checks++; if (k != 5) begin n_fail++; $display("FAIL starve_budget fp=%0d got %0d transfers want 5", fp, k); end
    if (fp) begin
      n_checks++; if (served3 != -1) begin n_fail++; $display("FAIL fixed_prio_ch3 got served at %0d want never", served3); end
    end else begin
      n_checks++; if (served3 < 0 || served3 > N - 1) begin n_fail++; $display("FAIL rr_fairness ch3 served at %0d want within %0d", served3, N); end
    end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    for (int t = 0; t < 16; t++) begin
      next_cycle();
      if (t == 0) set_req(2, 1'b1, 30'h222, 32'hCAFE0002, 4'hF);
      if (t == 1) set_req(1, 1'b0, 30'h111, 32'h0, 4'hF);
      if (t == 11 || t == 14) begin bus_ready = 1'b1; bus_data_rd = 32'h0BAD0000 + t; end
      #1;
      n_checks++; if (obs_bus_start !== (t == 2 || t == 12)) begin n_fail++; $display("FAIL tmo_bus_start t=%0d got %b", t, obs_bus_start); end
      if (t == 2) begin
        n_checks++; if (obs_bus_addr !== 30'h222 || obs_bus_write !== 1'b1) begin n_fail++; $display("FAIL tmo_issue2 got addr %h wr %b want 222/1", obs_bus_addr, obs_bus_write); end
      end
      if (t == 12) begin
        n_checks++; if (obs_bus_addr !== 30'h111) begin n_fail++; $display("FAIL tmo_next_issue got addr %h want 111", obs_bus_addr); end
      end
      n_checks++; if (obs_ch_fault !== ((t == 10) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL tmo_fault t=%0d got %b", t, obs_ch_fault); end
      n_checks++; if (obs_ch_ready !== ((t == 14) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL tmo_ready t=%0d got %b", t, obs_ch_ready); end
    end
    // ready on the last watchdog cycle completes normally
    for (int u = 0; u < 12; u++) begin
      next_cycle();
      if (u == 0) set_req(0, 1'b0, 30'h0AA, 32'h0, 4'hF);
      if (u == 10) begin bus_ready = 1'b1; bus_data_rd = 32'h600D600D; end
      #1;
      n_checks++; if (obs_ch_fault !== 4'b0000) begin n_fail++; $display("FAIL tmo_tie_fault u=%0d got %b want 0", u, obs_ch_fault); end
      n_checks++; if (obs_ch_ready !== ((u == 10) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL tmo_tie_ready u=%0d got %b", u, obs_ch_ready); end
    end
  endtask

  task automatic test_same_cycle_restart();
    do_reset(1'b0);
    for (int t = 0; t < 9; t++) begin
      next_cycle();
      if (t == 0) set_req(1, 1'b1, 30'h111, 32'h5555, 4'hF);
      if (t == 4) begin bus_ready = 1'b1; set_req(1, 1'b1, 30'h112, 32'h1234, 4'b0011); end
      if (t == 7) bus_ready = 1'b1;
      #1;
      n_checks++; if (obs_bus_start !== (t == 2 || t == 6)) begin n_fail++; $display("FAIL restart_bus_start t=%0d got %b", t, obs_bus_start); end
      if (t == 6) begin
        n_checks++; if (obs_bus_addr !== 30'h112) begin n_fail++; $display("FAIL restart_addr got %h want 112", obs_bus_addr); end
        n_checks++; if (obs_bus_data_wr !== 32'h1234) begin n_fail++; $display("FAIL restart_data got %h want 1234", obs_bus_data_wr); end
        n_checks++; if (obs_bus_data_be !== 4'b0011) begin n_fail++; $display("FAIL restart_be got %b want 0011", obs_bus_data_be); end
      end
      n_checks++; if (obs_ch_ready !== ((t == 4 || t == 7) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL restart_ready t=%0d got %b", t, obs_ch_ready); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int t = 0; t < 13; t++) begin
      next_cycle();
      if (t == 0) begin
        set_req(0, 1'b0, 30'h0C0, 32'h0, 4'hF);
        set_req(2, 1'b0, 30'h0C2, 32'h0, 4'hF);
      end
      if (t == 4) rst_rr = 1'b1;
      if (t == 5) rst_rr = 1'b0;
      if (t == 5 || t == 6 || t == 9) bus_ready = 1'b1;
      #1;
      if (t == 2) begin
        n_checks++; if (obs_bus_start !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue got %b want 1", obs_bus_start); end
      end
      if (t >= 5) begin
        n_checks++; if (obs_bus_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus_start t=%0d got %b want 0", t, obs_bus_start); end
      end
      n_checks++; if (obs_ch_ready !== 4'b0000 || obs_ch_fault !== 4'b0000) begin n_fail++; $display("FAIL rstmid_done t=%0d got ready %b fault %b want 0", t, obs_ch_ready, obs_ch_fault); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0]  m_pend;
    int            m_s [N];
    logic [AW-1:0] m_addr [N];
    logic          m_wr [N];
    logic [DW-1:0] m_data [N];
    logic [BW-1:0] m_be [N];
    logic [N-1:0]  elig;
    int  m_last, m_free, m_g, rdy_at, g;
    bit  m_busy, exp_s;
    do_reset(1'b0);
    m_pend = '0; m_last = N - 1; m_free = 0; m_busy = 1'b0; m_g = 0; rdy_at = -1;
    for (int i = 0; i < N; i++) m_s[i] = 0;
    for (int t = 0; t < 400; t++) begin
      next_cycle();
      bus_data_rd = $urandom;
      bus_ready   = m_busy && (t == rdy_at);
      for (int i = 0; i < N; i++) begin
        if (!m_pend[i] && $urandom_range(0, 3) == 0) begin
          m_addr[i] = AW'($urandom); m_wr[i] = 1'($urandom);
          m_data[i] = $urandom;      m_be[i] = BW'($urandom);
          set_req(i, m_wr[i], m_addr[i], m_data[i], m_be[i]);
          m_pend[i] = 1'b1; m_s[i] = t;
        end
      end
      #1;
      // a request is visible to arbitration two cycles after its start
      exp_s = 1'b0;
      elig  = '0;
      for (int i = 0; i < N; i++) elig[i] = m_pend[i] && (m_s[i] + 2 <= t);
      if (!m_busy && t >= m_free && elig != 0) exp_s = 1'b1;
      n_checks++; if (obs_bus_start !== exp_s) begin n_fail++; $display("FAIL rand_bus_start t=%0d got %b want %b", t, obs_bus_start, exp_s); end
      if (exp_s) begin
        g = rule_pick(elig, m_last, 1'b0);
        n_checks++; if (obs_bus_addr !== m_addr[g] || obs_bus_write !== m_wr[g] || obs_bus_data_wr !== m_data[g] || obs_bus_data_be !== m_be[g]) begin
          n_fail++; $display("FAIL rand_issue t=%0d ch %0d got %h/%b/%h/%h want %h/%b/%h/%h", t, g, obs_bus_addr, obs_bus_write, obs_bus_data_wr, obs_bus_data_be, m_addr[g], m_wr[g], m_data[g], m_be[g]);
        end
        m_busy = 1'b1; m_g = g; rdy_at = t + 1 + $urandom_range(0, 3);
      end
      n_checks++; if (obs_ch_ready !== (bus_ready ? (4'b0001 << m_g) : 4'b0000)) begin n_fail++; $display("FAIL rand_ready t=%0d got %b", t, obs_ch_ready); end
      n_checks++; if (obs_ch_fault !== 4'b0000) begin n_fail++; $display("FAIL rand_fault t=%0d got %b want 0", t, obs_ch_fault); end
      if (bus_ready) begin
        n_checks++; if (obs_ch_data_rd !== bus_data_rd) begin n_fail++; $display("FAIL rand_data_rd got %h want %h", obs_ch_data_rd, bus_data_rd); end
        m_pend[m_g] = 1'b0; m_last = m_g; m_busy = 1'b0; m_free = t + 2;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "time limit");
  end

  initial begin
    sel_fp = 1'b0; rst_rr = 1'b1; rst_fp = 1'b1;
    ch_start = '0; ch_write = '0; ch_addr = '0; ch_data_wr = '0; ch_data_be = '0;
    bus_ready = 1'b0; bus_data_rd = '0;
    test_reset();
    test_single_read();
    test_rr_order();
    test_starve(1'b1);
    test_starve(1'b0);
    test_timeout();
    test_same_cycle_restart();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Parametrised N-channel arbiter that merges independent requesters (per-core insn/data ports, DMA, debug) onto one shared bus.
- Uses the existing single-pulse start / ready handshake.
- Successor to the fixed two-port insn/data merge inside the core's MMU path.
- Adds channel-count generalisation, request buffering, selectable round-robin or fixed priority, and a watchdog timeout that returns a fault to the stalled requester.

Parameters:
- N, 2, number of requester channels (2..16).
- ADDR_W, 30, word-address width (ptr).
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- FIXED_PRIO, 0, 0 = round-robin, 1 = lowest index always wins.
- TIMEOUT, 0, cycles to wait for bus_ready before faulting; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ch_start  in  N  single-cycle request pulse per channel
- ch_write  in  N  1 = write
- ch_addr  in  N*ADDR_W  request address, packed, channel 0 in LSBs
- ch_data_wr  in  N*DATA_W  write data
- ch_data_be  in  N*DATA_W/8  byte enables
- ch_ready  out  N  completion pulse per channel
- ch_fault  out  N  timeout pulse per channel
- ch_data_rd  out  DATA_W  read data, broadcast, valid with ch_ready
- bus_addr  out  ADDR_W
- bus_start  out  1
- bus_write  out  1
- bus_data_wr  out  DATA_W
- bus_data_be  out  DATA_W/8
- bus_ready  in  1
- bus_data_rd  in  DATA_W

Behaviour:
- Single clock domain; rst is synchronous and active-high.
- Reset values:
  - pending = 0, state = IDLE, last_grant = N-1, timeout counter = 0.
  - bus_start = 0; bus_addr, bus_write, bus_data_wr and bus_data_be = 0.
  - ch_ready = 0, ch_fault = 0.
- Request capture:
  - ch_start[i] sets pending[i] and registers that channel's addr/write/data/be into its slot.
  - ch_start[i] while pending[i] is already set is a protocol violation: ignored, and flagged by a bench assertion.
  - If ch_start[i] arrives in the same cycle pending[i] is cleared by completion, set wins and the new request is captured.
- State machine IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If any pending bit is set, select grant g.
  - Round-robin: first pending index after last_grant, wrapping N-1 -> 0.
  - FIXED_PRIO: lowest pending index.
  - Go to ISSUE, loading bus_* fields from slot g.
- ISSUE: bus_start = 1 for exactly one cycle, then go to WAIT. bus_addr/write/data/be stay stable from ISSUE until WAIT exits.
- WAIT, on bus_ready:
  - ch_ready[g] = 1 in the same cycle (combinational) and ch_data_rd = bus_data_rd.
  - Clear pending[g], set last_grant = g, go to IDLE.
- Latency:
  - Isolated request with ch_start at cycle t: bus_start at t+2.
  - After a ready at cycle t, the next queued request sees bus_start at t+2.
  - Minimum bus occupancy is 3 cycles per transfer.
- Watchdog (TIMEOUT > 0):
  - Counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without bus_ready: ch_fault[g] = 1 for one cycle, pending[g] cleared, go to IDLE.
  - A bus_ready arriving later is ignored while not in WAIT.
  - bus_ready and the timeout in the same cycle: ready wins, no fault.
- bus_ready outside WAIT has no effect.
- Reset mid-transaction:
  - All pending requests are dropped and no ch_ready or ch_fault is emitted.
  - Requesters must reissue.
- Round-robin gives every channel a service bound of N transfers. No starvation is possible except in FIXED_PRIO.

Decomposition:
- Shared package core_bus_pkg:
  - arb_state enum {IDLE, ISSUE, WAIT}.
  - Slot struct {addr, write, data, be}.
  - Localparam BE_W = DATA_W/8.
- Sub-module core_bus_arb_pick:
  - Combinational rotate-priority picker.
  - Inputs: pending[N], last_grant, fixed_prio.
  - Outputs: grant index and valid.
  - Reused later by the interrupt controller.

Test Plan:
- N=2, ch0 read addr 0x100 at t=0, bus_ready at t=4 with 0xDEADBEEF -> bus_start at t=2 with bus_addr=0x100, write=0; ch_ready[0]=1 and ch_data_rd=0xDEADBEEF at t=4.
- N=4 RR, all four start in the same cycle, ready 1 cycle after each bus_start -> grant order 0,1,2,3; then ch1 and ch3 restart -> next order 1 then 3 after last_grant=3 wraps.
- N=4 FIXED_PRIO=1, ch3 pending and ch0 re-requesting continuously -> ch0 served each time and ch3 starves; with FIXED_PRIO=0, ch3 is served within 4 transfers.
- TIMEOUT=8, ch2 write with no bus_ready -> ch_fault[2]=1 on the 8th WAIT cycle, no ch_ready; late bus_ready ignored; the next pending request is issued.
- ch1 start on the same cycle its ch_ready fires, with be=0b0011 and data 0x1234 -> second request captured and issued with those values.
- rst asserted during WAIT with two pending -> next cycle bus_start=0 and pending=0; bus_ready afterwards produces no ch_ready.
